// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Brief  : Shared types, default geometry and width helper for param_sync_ram.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic {CLEAR, READY} ram_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;

  // A single-word memory still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_array.sv
// ============================================================================
// Module : ram_array
// Brief  : Plain DATA_W x DEPTH storage, one write port, combinational read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/param_sync_ram.sv
// ============================================================================
// Module : param_sync_ram
// Brief  : Single-port synchronous RAM with post-reset clear sweep, registered
//          read + valid strobe, write-first bypass and out-of-range flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module param_sync_ram
  import ram_pkg::*;
#(
  parameter int              DATA_W         = DEF_DATA_W,
  parameter int              DEPTH          = DEF_DEPTH,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
  localparam int             ADDR_W         = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              rd_valid,
  output logic              busy,
  output logic              adr_err
);

  localparam int                AW1       = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              adr_err_q, adr_err_d;

  logic              adr_ok;
  logic              accept_rd, accept_wr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign adr_ok    = ({1'b0, adr} < DEPTH_EXT);
  assign accept_rd = (state_q == READY) && rd;
  assign accept_wr = (state_q == READY) && wr;

  always_comb begin
    ram_we      = 1'b0;
    ram_waddr   = adr;
    ram_wdata   = WriteData;
    read_data_d = read_data_q;
    rd_valid_d  = accept_rd;
    adr_err_d   = (accept_rd || accept_wr) && !adr_ok;
    if (state_q == CLEAR) begin
      ram_we    = !rst;
      ram_waddr = cnt_q;
      ram_wdata = CLEAR_VALUE;
    end else begin
      ram_we = !rst && accept_wr && adr_ok;
    end
    // Write-first: a same-cycle write wins over the stored word.
    if (accept_rd) begin
      if (!adr_ok) begin
        read_data_d = '0;
      end else if (wr) begin
        read_data_d = WriteData;
      end else begin
        read_data_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q       <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      adr_err_q   <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      adr_err_q   <= adr_err_d;
      if (state_q == CLEAR) begin
        if (cnt_q == LAST_CNT) begin
          state_q <= READY;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (adr),
    .rdata_o (ram_rdata)
  );

  assign ReadData = read_data_q;
  assign rd_valid = rd_valid_q;
  assign adr_err  = adr_err_q;
  assign busy     = (state_q == CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_param_sync_ram.sv
// ============================================================================
// Module : tb_param_sync_ram
// Brief  : Directed checks of param_sync_ram in three geometries sharing stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_sync_ram;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [5:0]  adr;
  logic [15:0] wdata;

  logic [7:0]  rdata_a, rdata_b;
  logic [15:0] rdata_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n_busy, n_busy_c;

  always #5 clk = ~clk;

  // A: default 8x32, B: 8x20 (non power of two), C: 16x64 without sweep.
  param_sync_ram #(.DATA_W(8), .DEPTH(32)) dut_a (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .adr(adr[4:0]), .WriteData(wdata[7:0]),
    .ReadData(rdata_a), .rd_valid(valid_a), .busy(busy_a), .adr_err(err_a)
  );

  param_sync_ram #(.DATA_W(8), .DEPTH(20)) dut_b (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .adr(adr[4:0]), .WriteData(wdata[7:0]),
    .ReadData(rdata_b), .rd_valid(valid_b), .busy(busy_b), .adr_err(err_b)
  );

  param_sync_ram #(.DATA_W(16), .DEPTH(64), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .adr(adr), .WriteData(wdata),
    .ReadData(rdata_c), .rd_valid(valid_c), .busy(busy_c), .adr_err(err_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle first, then advances; 40 cycles covers a 32-word sweep.
  task automatic count_busy(output int na, output int nc);
    na = 0;
    nc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) na++;
      if (busy_c) nc++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; adr = '0; wdata = '0;
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy_a",  {15'd0, busy_a},  16'd1);
    chk("rst_valid_a", {15'd0, valid_a}, 16'd0);
    chk("rst_err_a",   {15'd0, err_a},   16'd0);
    chk("rst_data_a",  {8'd0, rdata_a},  16'h0000);
    chk("rst_busy_c",  {15'd0, busy_c},  16'd0);
    chk("rst_data_c",  rdata_c,          16'h0000);

    // T1: sweep length, then every word reads back as zero
    count_busy(n_busy, n_busy_c);
    chk("t1_busy_len", n_busy[15:0],   16'd32);
    chk("t6_busy_c",   n_busy_c[15:0], 16'd0);
    rd = 1'b1;
    for (int a = 0; a < 32; a++) begin
      adr = 6'(a);
      tick();
      chk($sformatf("t1_rd%0d_data", a), {8'd0, rdata_a}, 16'h0000);
      chk($sformatf("t1_rd%0d_vld", a),  {15'd0, valid_a}, 16'd1);
    end
    rd = 1'b0;

    // T2: write then read, then hold
    wr = 1'b1; adr = 6'd5; wdata = 16'h00A7;
    tick();
    chk("t2_wr_vld", {15'd0, valid_a}, 16'd0);
    chk("t2_wr_err", {15'd0, err_a},   16'd0);
    wr = 1'b0; rd = 1'b1;
    tick();
    chk("t2_rd_data", {8'd0, rdata_a}, 16'h00A7);
    chk("t2_rd_vld",  {15'd0, valid_a}, 16'd1);
    rd = 1'b0;
    tick();
    chk("t2_idle_vld",  {15'd0, valid_a}, 16'd0);
    chk("t2_idle_hold", {8'd0, rdata_a},  16'h00A7);

    // T3: write-first on simultaneous rd/wr
    wr = 1'b1; adr = 6'd9; wdata = 16'h0011;
    tick();
    rd = 1'b1; wdata = 16'h003C;
    tick();
    chk("t3_bypass",     {8'd0, rdata_a},  16'h003C);
    chk("t3_bypass_vld", {15'd0, valid_a}, 16'd1);
    wr = 1'b0;
    tick();
    chk("t3_reread", {8'd0, rdata_a}, 16'h003C);
    rd = 1'b0;

    // T4: out-of-range on the 20-word instance
    wr = 1'b1; adr = 6'd25; wdata = 16'h00FF;
    tick();
    chk("t4_wr_err_b", {15'd0, err_b},   16'd1);
    chk("t4_wr_vld_b", {15'd0, valid_b}, 16'd0);
    chk("t4_wr_err_a", {15'd0, err_a},   16'd0);
    wr = 1'b0; rd = 1'b1;
    tick();
    chk("t4_rd_data_b", {8'd0, rdata_b},  16'h0000);
    chk("t4_rd_vld_b",  {15'd0, valid_b}, 16'd1);
    chk("t4_rd_err_b",  {15'd0, err_b},   16'd1);
    chk("t4_rd_data_a", {8'd0, rdata_a},  16'h00FF);
    adr = 6'd19;
    tick();
    chk("t4_last_b",    {8'd0, rdata_b}, 16'h0000);
    chk("t4_err_pulse", {15'd0, err_b},  16'd0);
    adr = 6'd9;
    tick();
    chk("t4_keep9_b", {8'd0, rdata_b}, 16'h003C);
    adr = 6'd5;
    tick();
    chk("t4_keep5_b", {8'd0, rdata_b}, 16'h00A7);
    rd = 1'b0;

    // T6: wide instance without sweep
    wr = 1'b1; adr = 6'd63; wdata = 16'hBEEF;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    chk("t6_data_c", rdata_c,          16'hBEEF);
    chk("t6_vld_c",  {15'd0, valid_c}, 16'd1);
    chk("t6_err_c",  {15'd0, err_c},   16'd0);
    rd = 1'b0;

    // T5: requests during the sweep are dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    wr = 1'b1; rd = 1'b1; adr = 6'd2; wdata = 16'h0055;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_busy_vld_a", {15'd0, valid_a}, 16'd0);
      chk("t5_busy_err_a", {15'd0, err_a},   16'd0);
    end
    adr = 6'd25;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_busy_vld_b", {15'd0, valid_b}, 16'd0);
      chk("t5_busy_err_b", {15'd0, err_b},   16'd0);
    end
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 23; i++) tick();
    chk("t5_sweep_done", {15'd0, busy_a}, 16'd0);
    rd = 1'b1; adr = 6'd2;
    tick();
    chk("t5_no_write", {8'd0, rdata_a}, 16'h0000);
    rd = 1'b0;

    // T5: reset in sweep cycle 10 restarts the full sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_mid_busy", {15'd0, busy_a}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n_busy, n_busy_c);
    chk("t5_restart_len", n_busy[15:0],   16'd32);
    chk("t5_busy_c",      n_busy_c[15:0], 16'd0);
    rd = 1'b1; adr = 6'd5;
    tick();
    chk("t5_recleared5", {8'd0, rdata_a}, 16'h0000);
    adr = 6'd31;
    tick();
    chk("t5_recleared31", {8'd0, rdata_a}, 16'h0000);
    rd = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
